// File: rtl/ps2_key_mapper.sv
// Maps PS/2 driver level output {ps2_state, ps2_byte} to game key levels/pulses; event at edge E, key_hold at E+1.
// No backpressure: every change of the input pair is accepted, including back-to-back changes.
module ps2_key_mapper #(
    parameter int EXT_TIMEOUT = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_state,
    output logic [7:0] key_hold,
    output logic [7:0] key_press,
    output logic       event_stb,
    output logic [8:0] event_code,
    output logic       event_make
);

    localparam int CNT_W = (EXT_TIMEOUT > 2) ? $clog2(EXT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_TIMEOUT - 1);
    localparam logic [7:0] PREFIX_E0 = 8'hE0;

    logic             last_state_q, last_state_d;
    logic [7:0]       last_byte_q, last_byte_d;
    logic             ext_pending_q, ext_pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [12:0]      src_q, src_d;
    logic [7:0]       key_hold_q, key_hold_d;
    logic [7:0]       key_press_q, key_press_d;
    logic             event_stb_q, event_stb_d;
    logic [8:0]       event_code_q, event_code_d;
    logic             event_make_q, event_make_d;

    logic       evt;
    logic       is_prefix;
    logic [8:0] code;

    assign evt       = ({ps2_state, ps2_byte} != {last_state_q, last_byte_q});
    assign is_prefix = (ps2_byte == PREFIX_E0);
    // The decoded code uses the prefix flag as it stood before this edge, so an
    // event coinciding with the timeout still sees the prefix.
    assign code      = {ext_pending_q, ps2_byte};

    always_comb begin
        last_state_d  = last_state_q;
        last_byte_d   = last_byte_q;
        ext_pending_d = ext_pending_q;
        cnt_d         = cnt_q;
        src_d         = src_q;
        event_stb_d   = 1'b0;
        event_code_d  = event_code_q;
        event_make_d  = event_make_q;

        if (evt) begin
            last_state_d = ps2_state;
            last_byte_d  = ps2_byte;
            cnt_d        = '0;
            event_stb_d  = 1'b1;
            event_make_d = ps2_state;
            event_code_d = code;
            if (is_prefix) begin
                ext_pending_d = 1'b1;
            end else begin
                ext_pending_d = 1'b0;
                case (code)
                    9'h16B:  src_d[0]  = ps2_state;
                    9'h01C:  src_d[1]  = ps2_state;
                    9'h174:  src_d[2]  = ps2_state;
                    9'h023:  src_d[3]  = ps2_state;
                    9'h175:  src_d[4]  = ps2_state;
                    9'h01D:  src_d[5]  = ps2_state;
                    9'h029:  src_d[6]  = ps2_state;
                    9'h172:  src_d[7]  = ps2_state;
                    9'h01B:  src_d[8]  = ps2_state;
                    9'h03B:  src_d[9]  = ps2_state;
                    9'h042:  src_d[10] = ps2_state;
                    9'h05A:  src_d[11] = ps2_state;
                    9'h076:  src_d[12] = ps2_state;
                    default: src_d     = src_q;
                endcase
            end
        end else if (ext_pending_q) begin
            if (cnt_q == CNT_LAST) begin
                ext_pending_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Several physical keys share a function; the function stays held while any is down.
    always_comb begin
        key_hold_d[0] = src_q[0] | src_q[1];
        key_hold_d[1] = src_q[2] | src_q[3];
        key_hold_d[2] = src_q[4] | src_q[5] | src_q[6];
        key_hold_d[3] = src_q[7] | src_q[8];
        key_hold_d[4] = src_q[9];
        key_hold_d[5] = src_q[10];
        key_hold_d[6] = src_q[11];
        key_hold_d[7] = src_q[12];
        key_press_d   = key_hold_d & ~key_hold_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_state_q  <= 1'b0;
            last_byte_q   <= 8'h00;
            ext_pending_q <= 1'b0;
            cnt_q         <= '0;
            src_q         <= '0;
            key_hold_q    <= '0;
            key_press_q   <= '0;
            event_stb_q   <= 1'b0;
            event_code_q  <= '0;
            event_make_q  <= 1'b0;
        end else begin
            last_state_q  <= last_state_d;
            last_byte_q   <= last_byte_d;
            ext_pending_q <= ext_pending_d;
            cnt_q         <= cnt_d;
            src_q         <= src_d;
            key_hold_q    <= key_hold_d;
            key_press_q   <= key_press_d;
            event_stb_q   <= event_stb_d;
            event_code_q  <= event_code_d;
            event_make_q  <= event_make_d;
        end
    end

    assign key_hold   = key_hold_q;
    assign key_press  = key_press_q;
    assign event_stb  = event_stb_q;
    assign event_code = event_code_q;
    assign event_make = event_make_q;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper with a short prefix timeout.
module tb_ps2_key_mapper;

    logic       clk;
    logic       rst;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic [7:0] key_hold;
    logic [7:0] key_press;
    logic       event_stb;
    logic [8:0] event_code;
    logic       event_make;

    int n_assert;
    int n_fail;
    int stb_count;

    ps2_key_mapper #(.EXT_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_byte   (ps2_byte),
        .ps2_state  (ps2_state),
        .key_hold   (key_hold),
        .key_press  (key_press),
        .event_stb  (event_stb),
        .event_code (event_code),
        .event_make (event_make)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [7:0] b);
        ps2_state = st;
        ps2_byte  = b;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},  16'(key_hold),   16'h0);
        chk({tag, "_press"}, 16'(key_press),  16'h0);
        chk({tag, "_stb"},   16'(event_stb),  16'h0);
        chk({tag, "_code"},  16'(event_code), 16'h0);
        chk({tag, "_make"},  16'(event_make), 16'h0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        stb_count = 0;
        rst       = 1'b0;
        drive(1'b0, 8'h00);
        step();
        chk_all_zero("reset");
        step();
        rst = 1'b1;

        // plain press/release of A
        drive(1'b1, 8'h1C);
        step();
        chk("a_mk_stb",  16'(event_stb),  16'h1);
        chk("a_mk_code", 16'(event_code), 16'h01C);
        chk("a_mk_make", 16'(event_make), 16'h1);
        chk("a_mk_hold0", 16'(key_hold),  16'h00);
        step();
        chk("a_hold",    16'(key_hold),   16'h01);
        chk("a_press",   16'(key_press),  16'h01);
        chk("a_stb_low", 16'(event_stb),  16'h0);
        step();
        chk("a_press_end", 16'(key_press), 16'h00);
        chk("a_hold_kept", 16'(key_hold),  16'h01);
        step(); step(); step();
        drive(1'b0, 8'h1C);
        step();
        chk("a_br_stb",  16'(event_stb),  16'h1);
        chk("a_br_make", 16'(event_make), 16'h0);
        chk("a_br_hold_lag", 16'(key_hold), 16'h01);
        step();
        chk("a_br_hold", 16'(key_hold),  16'h00);
        chk("a_br_press", 16'(key_press), 16'h00);

        // extended right arrow
        drive(1'b1, 8'hE0);
        step();
        chk("e0_stb",  16'(event_stb),  16'h1);
        chk("e0_code", 16'(event_code), 16'h0E0);
        drive(1'b1, 8'h74);
        step();
        chk("rt_stb",  16'(event_stb),  16'h1);
        chk("rt_code", 16'(event_code), 16'h174);
        step();
        chk("rt_hold",  16'(key_hold),  16'h02);
        chk("rt_press", 16'(key_press), 16'h02);
        step();
        drive(1'b1, 8'hE0);
        step();
        chk("e0b_stb", 16'(event_stb), 16'h1);
        drive(1'b0, 8'h74);
        step();
        chk("rt_br_code", 16'(event_code), 16'h174);
        chk("rt_br_make", 16'(event_make), 16'h0);
        step();
        chk("rt_br_hold",  16'(key_hold),  16'h00);
        chk("rt_br_press", 16'(key_press), 16'h00);

        // shared JUMP function: space and W
        drive(1'b1, 8'h29);
        step();
        drive(1'b1, 8'h1D);
        step();
        chk("jmp_hold",  16'(key_hold),  16'h04);
        chk("jmp_press", 16'(key_press), 16'h04);
        drive(1'b0, 8'h29);
        step();
        chk("jmp_w_press", 16'(key_press), 16'h00);
        step();
        chk("jmp_sp_rel_hold",  16'(key_hold),  16'h04);
        chk("jmp_sp_rel_press", 16'(key_press), 16'h00);
        drive(1'b0, 8'h1D);
        step();
        step();
        chk("jmp_rel_hold", 16'(key_hold), 16'h00);

        // prefix still live on the last cycle before timeout
        drive(1'b1, 8'hE0);
        step();
        for (int i = 0; i < 7; i++) step();
        drive(1'b1, 8'h6B);
        step();
        chk("to_edge_code", 16'(event_code), 16'h16B);
        step();
        chk("to_edge_hold", 16'(key_hold), 16'h01);
        drive(1'b1, 8'hE0);
        step();
        drive(1'b0, 8'h6B);
        step();
        chk("lf_br_code", 16'(event_code), 16'h16B);
        step();
        chk("lf_br_hold", 16'(key_hold), 16'h00);

        // prefix expired
        drive(1'b1, 8'hE0);
        step();
        for (int i = 0; i < 10; i++) step();
        drive(1'b1, 8'h6B);
        step();
        chk("to_stb",  16'(event_stb),  16'h1);
        chk("to_code", 16'(event_code), 16'h06B);
        step();
        chk("to_hold", 16'(key_hold), 16'h00);

        // no retrigger on an unchanged pair
        drive(1'b1, 8'h1C);
        for (int i = 0; i < 100; i++) begin
            step();
            if (event_stb) stb_count++;
        end
        chk("rpt_count", 16'(stb_count), 16'd1);
        chk("rpt_hold",  16'(key_hold),  16'h01);
        drive(1'b1, 8'h0E);
        step();
        chk("unm_stb",  16'(event_stb),  16'h1);
        chk("unm_code", 16'(event_code), 16'h00E);
        step();
        chk("unm_hold",  16'(key_hold),  16'h01);
        chk("unm_press", 16'(key_press), 16'h00);

        // reset after a prefix discards it and forgets held keys
        drive(1'b1, 8'hE0);
        step();
        chk("rst_e0_stb", 16'(event_stb), 16'h1);
        rst = 1'b0;
        #1;
        chk_all_zero("in_rst");
        step();
        step();
        drive(1'b1, 8'h74);
        step();
        chk_all_zero("in_rst_end");
        rst = 1'b1;
        step();
        chk("post_rst_stb",  16'(event_stb),  16'h1);
        chk("post_rst_code", 16'(event_code), 16'h074);
        step();
        chk("post_rst_hold", 16'(key_hold), 16'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
